// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle main control FSM (FETCH/DECODE/EXEC/MEM/WB)
module multicycle_ctrl #(
  parameter int OP_W     = 6,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic [OP_W-1:0]     instr_op_i,
  input  logic                mem_ready_i,
  input  logic                zero_i,
  output logic                pc_write_o,
  output logic                ir_write_o,
  output logic                mem_read_o,
  output logic                mem_write_o,
  output logic                reg_write_o,
  output logic                reg_dst_o,
  output logic                alu_src_o,
  output logic                mem_to_reg_o,
  output logic                branch_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                illegal_o,
  output logic                retire_o,
  output logic [CNT_W-1:0]    instr_cnt_o,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'h0A);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h2B);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h04);

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(2'd0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(2'd1);
  localparam logic [ALU_OP_W-1:0] ALU_FUNC = ALU_OP_W'(2'd2);
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = ALU_OP_W'(2'd3);

  state_t            state;
  state_t            state_nxt;
  logic [OP_W-1:0]   op_q;
  logic              ready;
  logic              supported;
  logic              is_r;
  logic              is_slti;
  logic              is_lw;
  logic              is_sw;
  logic              is_beq;
  logic [ALU_OP_W-1:0] exec_alu_op;
  logic              exec_alu_src;

  // Reset masks the handshake so FETCH never loads IR/PC while held in reset.
  assign ready = mem_ready_i & rst_n;

  assign supported = (instr_op_i == OP_R)   || (instr_op_i == OP_ADDI) ||
                     (instr_op_i == OP_SLTI)|| (instr_op_i == OP_LW)   ||
                     (instr_op_i == OP_SW)  || (instr_op_i == OP_BEQ);

  assign is_r    = (op_q == OP_R);
  assign is_slti = (op_q == OP_SLTI);
  assign is_lw   = (op_q == OP_LW);
  assign is_sw   = (op_q == OP_SW);
  assign is_beq  = (op_q == OP_BEQ);

  always_comb begin
    exec_alu_op  = ALU_ADD;
    exec_alu_src = 1'b1;
    if (is_r) begin
      exec_alu_op  = ALU_FUNC;
      exec_alu_src = 1'b0;
    end else if (is_slti) begin
      exec_alu_op  = ALU_SLT;
    end else if (is_beq) begin
      exec_alu_op  = ALU_SUB;
      exec_alu_src = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      op_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        op_q <= instr_op_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_o <= '0;
    end else if (retire_o) begin
      instr_cnt_o <= instr_cnt_o + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    alu_src_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    branch_o     = 1'b0;
    alu_op_o     = ALU_ADD;
    illegal_o    = 1'b0;
    retire_o     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read_o = 1'b1;
        if (ready) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_nxt  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (supported) begin
          state_nxt = S_EXEC;
        end else begin
          illegal_o = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_op_o  = exec_alu_op;
        alu_src_o = exec_alu_src;
        if (is_beq) begin
          branch_o   = zero_i;
          pc_write_o = zero_i;
          retire_o   = 1'b1;
          state_nxt  = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        // Address operands stay on the ALU for the whole access.
        alu_op_o    = ALU_ADD;
        alu_src_o   = 1'b1;
        mem_read_o  = is_lw;
        mem_write_o = is_sw;
        if (ready) begin
          if (is_lw) begin
            state_nxt = S_WB;
          end else begin
            retire_o  = is_sw;
            state_nxt = S_FETCH;
          end
        end
      end
      S_WB: begin
        alu_op_o     = exec_alu_op;
        alu_src_o    = exec_alu_src;
        reg_write_o  = 1'b1;
        retire_o     = 1'b1;
        reg_dst_o    = is_r;
        mem_to_reg_o = is_lw;
        state_nxt    = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  assign state_o = state;

endmodule
